// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kyber_pkg
// Purpose  : Shared constants, tag type and FSM encoding for the mod-q
//            divider arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package kyber_pkg;

  // Kyber modulus, driven as the constant divisor
  localparam logic [15:0] KYBER_Q = 16'd3329;

  // Widest supported requester count and the index width that covers it
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // One entry of the in-flight tag pipeline
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Drain handshake states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // One-hot decode of a requester index, sized for the widest build
  function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modq_div_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : modq_div_arbiter_if
// Purpose  : Requester, drain and divider-side signals of the mod-q divider
//            arbiter. slave = arbiter view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface modq_div_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_dividend;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_data;
  logic                  drain;
  logic                  drain_done;
  logic                  busy;
  logic                  err;
  logic [15:0]           div_dividend_tdata;
  logic                  div_dividend_tvalid;
  logic [15:0]           div_divisor_tdata;
  logic                  div_divisor_tvalid;
  logic                  div_dout_tvalid;
  logic [31:0]           div_dout_tdata;

  modport slave (
    input  req_valid, req_dividend, drain, div_dout_tvalid, div_dout_tdata,
    output req_ready, resp_valid, resp_data, drain_done, busy, err,
           div_dividend_tdata, div_dividend_tvalid,
           div_divisor_tdata, div_divisor_tvalid
  );

  modport master (
    output req_valid, req_dividend, drain, div_dout_tvalid, div_dout_tdata,
    input  req_ready, resp_valid, resp_data, drain_done, busy, err,
           div_dividend_tdata, div_dividend_tvalid,
           div_divisor_tdata, div_divisor_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/modq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modq_rr_arbiter
// Purpose  : Combinational single-grant arbiter. Round-robin starting one
//            past ptr; with MODQ_DIV_ARB_FIXED_PRIO_EN defined it becomes a
//            fixed lowest-index-wins arbiter and the ptr port disappears.
// Revision : 1.0 - initial release
// ============================================================================
module modq_rr_arbiter
  import kyber_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef MODQ_DIV_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

`ifndef MODQ_DIV_ARB_FIXED_PRIO_EN
  localparam int DW = IDX_W + 1;

  logic [DW-1:0] w_dist;
  logic [DW-1:0] w_best;

  // Pick the requester at the smallest circular distance after ptr
  always_comb begin
    w_dist    = '0;
    w_best    = DW'(NUM_REQ);
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (DW'(i) > {1'b0, ptr}) begin
        w_dist = DW'(i) - {1'b0, ptr} - DW'(1);
      end else begin
        w_dist = DW'(i) + DW'(NUM_REQ) - {1'b0, ptr} - DW'(1);
      end
      if (req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  // Lowest set request wins; scan from the top so the lowest index lands last
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Expand the winning index into the one-hot grant
  always_comb begin
    grant_any = |req;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (grant_idx == IDX_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/modq_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modq_div_arbiter
// Purpose  : Shares one fixed-latency pipelined mod-q divider among NUM_REQ
//            requesters. Each issue is tagged through a shift pipeline
//            aligned with the divider so remainders route back to their
//            issuer. Includes a drain handshake for quiescing the divider.
//            Build option MODQ_DIV_ARB_FIXED_PRIO_EN selects fixed priority
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module modq_div_arbiter
  import kyber_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 20
) (
  input  logic              clk,
  input  logic              rst,
  modq_div_arbiter_if.slave bus
);

  localparam int BLANK_W = $clog2(DIV_LATENCY + 2);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic                      w_grant_en;
  logic [NUM_REQ-1:0]        w_grant;
  logic [IDX_W-1:0]          w_grant_idx;
  logic                      w_grant_any;
  logic [15:0]               w_sel_operand;
  logic [15:0]               r_dividend;
  logic                      r_in_valid;
  tag_t                      w_new_tag;
  tag_t [DIV_LATENCY:0]      r_tag_pipe;
  tag_t                      w_head;
  logic                      w_busy;
  logic [NUM_REQ-1:0]        r_resp_valid;
  logic [15:0]               r_resp_data;
  logic                      r_drain_done;
  logic                      r_err;
  logic [BLANK_W-1:0]        r_blank_cnt;
  logic                      unused_quot;

  // Grants only while running, not draining, and out of reset
  always_comb begin
    w_grant_en = (r_state == RUN) && !bus.drain && !rst;
  end

`ifndef MODQ_DIV_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_ptr;

  // Last granted index; reset so that index 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_grant_any) begin
      r_ptr <= w_grant_idx;
    end
  end
`endif

  modq_rr_arbiter #(
    .NUM_REQ   (NUM_REQ)
  ) u_arb (
    .req       (bus.req_valid & {NUM_REQ{w_grant_en}}),
`ifndef MODQ_DIV_ARB_FIXED_PRIO_EN
    .ptr       (r_ptr),
`endif
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // Select the granted requester's operand
  always_comb begin
    w_sel_operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_operand = bus.req_dividend[16*i +: 16];
      end
    end
  end

  // Divider input register; valid pulses one cycle per accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend <= '0;
      r_in_valid <= 1'b0;
    end else begin
      r_in_valid <= w_grant_any;
      if (w_grant_any) begin
        r_dividend <= w_sel_operand;
      end
    end
  end

  // Tag entering the pipeline alongside the divider input
  always_comb begin
    w_new_tag.valid = w_grant_any;
    w_new_tag.idx   = w_grant_idx;
  end

  // Tag shift pipeline; stage 0 lines up with the divider input valid,
  // so the last stage lines up with dout_tvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_pipe <= '0;
    end else begin
      r_tag_pipe <= {r_tag_pipe[DIV_LATENCY-1:0], w_new_tag};
    end
  end

  // Head tag and in-flight summary
  always_comb begin
    w_head = r_tag_pipe[DIV_LATENCY];
    w_busy = r_in_valid;
    for (int i = 0; i <= DIV_LATENCY; i++) begin
      w_busy = w_busy | r_tag_pipe[i].valid;
    end
  end

  // Route the remainder back to the requester named by the head tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= '0;
      if (w_head.valid && bus.div_dout_tvalid) begin
        r_resp_valid <= NUM_REQ'(idx_onehot(w_head.idx));
        r_resp_data  <= bus.div_dout_tdata[15:0];
      end
    end
  end

  // After reset the divider may still emit results of pre-reset issues;
  // the mismatch check is held off until those have all drained out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank_cnt <= BLANK_W'(DIV_LATENCY + 1);
    end else if (r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - BLANK_W'(1);
    end
  end

  // Sticky flag for head-tag / divider-output disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_blank_cnt == '0) && (w_head.valid != bus.div_dout_tvalid)) begin
      r_err <= 1'b1;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (bus.drain) w_state_nxt = DRAIN;
      DRAIN:   if (!w_busy)   w_state_nxt = DONE;
      DONE:    if (!bus.drain) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // drain_done pulses once, on the cycle DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= (r_state == DRAIN) && (w_state_nxt == DONE);
    end
  end

  // Quotient half of the divider output is not needed
  assign unused_quot             = ^bus.div_dout_tdata[31:16];

  assign bus.req_ready           = w_grant;
  assign bus.resp_valid          = r_resp_valid;
  assign bus.resp_data           = r_resp_data;
  assign bus.drain_done          = r_drain_done;
  assign bus.busy                = w_busy;
  assign bus.err                 = r_err;
  assign bus.div_dividend_tdata  = r_dividend;
  assign bus.div_dividend_tvalid = r_in_valid;
  assign bus.div_divisor_tdata   = KYBER_Q;
  assign bus.div_divisor_tvalid  = r_in_valid;

endmodule
`default_nettype wire

// File: tb/tb_modq_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modq_div_arbiter
// Purpose  : Self-checking bench for modq_div_arbiter with a behavioural
//            divider and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modq_div_arbiter;
  import kyber_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 20;
  localparam int Q       = 3329;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modq_div_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  modq_div_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DIV_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural divider: fixed latency, not reset
  logic [LAT-1:0] dv_valid = '0;
  logic [15:0]    dv_rem [LAT];
  logic           inject = 1'b0;

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      dv_valid[k] <= dv_valid[k-1];
      dv_rem[k]   <= dv_rem[k-1];
    end
    dv_valid[0] <= bus.div_dividend_tvalid & bus.div_divisor_tvalid;
    dv_rem[0]   <= bus.div_dividend_tdata % bus.div_divisor_tdata;
  end

  assign bus.div_dout_tvalid = dv_valid[LAT-1] | inject;
  assign bus.div_dout_tdata  = {16'h0, dv_rem[LAT-1]};

  // Reference grant rule
  function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] v, input int p);
`ifdef MODQ_DIV_ARB_FIXED_PRIO_EN
    for (int j = 0; j < NUM_REQ; j++) if (v[j]) return NUM_REQ'(1) << j;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (p + k) % NUM_REQ;
      if (v[j]) return NUM_REQ'(1) << j;
    end
`endif
    return '0;
  endfunction

  // Reference model: expected responses with their due cycle
  typedef struct { int idx; int rem; int due; } exp_t;
  exp_t q[$];
  int   cyc    = 0;
  int   m_ptr  = NUM_REQ - 1;
  int   mode   = 0;          // 0 run, 1 draining, 2 done
  logic dd_exp = 1'b0;
  logic err_exp = 1'b0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] rv;
    logic               b;
    exp_t               e;
    cyc++;
    g = (!rst && mode == 0 && !bus.drain) ? model_grant(bus.req_valid, m_ptr) : '0;
    chk("req_ready", bus.req_ready, g);
    rv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      rv = NUM_REQ'(1) << q[0].idx;
      chk("resp_data", bus.resp_data, q[0].rem);
      void'(q.pop_front());
    end
    chk("resp_valid", bus.resp_valid, rv);
    b = (q.size() != 0);
    chk("busy", bus.busy, b);
    chk("drain_done", bus.drain_done, dd_exp);
    chk("err", bus.err, err_exp);
    if (rst) begin
      q.delete();
      m_ptr   = NUM_REQ - 1;
      mode    = 0;
      dd_exp  = 1'b0;
      err_exp = 1'b0;
    end else begin
      dd_exp = 1'b0;
      if (g != '0) begin
        for (int j = 0; j < NUM_REQ; j++) if (g[j]) e.idx = j;
        e.rem = int'(bus.req_dividend[16*e.idx +: 16]) % Q;
        e.due = cyc + LAT + 2;
        q.push_back(e);
        m_ptr = e.idx;
      end
      case (mode)
        0: if (bus.drain) mode = 1;
        1: if (!b) begin mode = 2; dd_exp = 1'b1; end
        default: if (!bus.drain) mode = 0;
      endcase
      if (inject) err_exp = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n3, pulses, pulse_k, last_resp_k, resumed;
    logic [NUM_REQ-1:0] exp_g;

    bus.req_valid    = '1;
    bus.req_dividend = {16'd7, 16'd8, 16'd9, 16'd10};
    bus.drain        = 1'b0;
    repeat (3) step();
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_dividend_tvalid", bus.div_dividend_tvalid, 0);
    chk("rst_divisor_tvalid", bus.div_divisor_tvalid, 0);
    chk("rst_dividend_tdata", bus.div_dividend_tdata, 0);
    chk("divisor_tdata", bus.div_divisor_tdata, Q);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    repeat (LAT + 4) step();

    // Contention: all four hold valid
    bus.req_dividend = {16'd0, 16'd100, 16'd6659, 16'd3329};
    bus.req_valid    = '1;
    for (int k = 0; k < 8; k++) begin
      #2;
`ifdef MODQ_DIV_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = NUM_REQ'(1) << (k % 4);
`endif
      chk("contention_grant", bus.req_ready, exp_g);
      step();
    end
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Single request from requester 2
    bus.req_dividend[47:32] = 16'd3330;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    repeat (LAT + 1) step();
    #2;
    chk("single_resp_valid", bus.resp_valid, 4'b0100);
    chk("single_resp_data", bus.resp_data, 1);
    repeat (4) step();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      bus.req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) bus.req_dividend[16*i +: 16] = 16'($urandom_range(0, 65535));
      step();
    end
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Requesters 0 and 3 held together
    n3 = 0;
    bus.req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      #2;
`ifdef MODQ_DIV_ARB_FIXED_PRIO_EN
      chk("fixed_prio_grant", bus.req_ready, 4'b0001);
`endif
      if (bus.req_ready[3]) n3++;
      step();
    end
`ifdef MODQ_DIV_ARB_FIXED_PRIO_EN
    chk("fixed_prio_req3_grants", n3, 0);
`else
    chk("rr_req3_grants", n3, 3);
`endif
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Drain: five issues from one requester, then drain with all valid
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      bus.req_dividend[31:16] = 16'($urandom_range(0, 65535));
      #2;
      chk("single_holder_grant", bus.req_ready, 4'b0010);
      step();
    end
    bus.drain     = 1'b1;
    bus.req_valid = '1;
    pulses = 0; pulse_k = -1; last_resp_k = -1;
    for (int k = 0; k < 3 * LAT; k++) begin
      #2;
      chk("drain_no_ready", bus.req_ready, 0);
      if (bus.resp_valid != '0) last_resp_k = k;
      if (bus.drain_done === 1'b1) begin pulses++; pulse_k = k; end
      step();
    end
    chk("drain_done_pulses", pulses, 1);
    chk("drain_done_after_resp", (pulse_k > last_resp_k) && (last_resp_k >= 0), 1);
    bus.drain = 1'b0;
    resumed = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (bus.req_ready != '0) resumed = 1;
      step();
    end
    chk("drain_resume", resumed, 1);
    bus.req_valid = '0;
    repeat (LAT + 4) step();

    // Reset mid-flight
    bus.req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_dividend[16*i +: 16] = 16'($urandom_range(0, 65535));
    repeat (4) step();
    bus.req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("rst_mid_busy", bus.busy, 0);
    for (int k = 0; k < LAT + 6; k++) begin
      step();
      #2;
      chk("rst_mid_resp_valid", bus.resp_valid, 0);
      chk("rst_mid_err", bus.err, 0);
    end
    repeat (LAT + 4) step();

    // Spurious divider output while idle
    inject = 1'b1;
    step();
    inject = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("tag_err_sticky", bus.err, 1);
      chk("tag_err_no_resp", bus.resp_valid, 0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("err_cleared_by_rst", bus.err, 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
